magma_encoder_pipe: RTL and testbench

//  Fully pipelined GOST R 34.12-2015 "Magma" 64-bit block cipher, encrypt direction only.

---
 rtl/magma_encoder_pipe_if.sv | 17 +
 rtl/magma_encoder_pipe.sv | 100 ++++++++++
 tb/tb_magma_encoder_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/magma_encoder_pipe_if.sv
// Block/key/ciphertext bundle for magma_encoder_pipe.
// MAGMA_ENCODER_VALID_EN adds in_valid/out_valid tracking signals.
interface magma_encoder_pipe_if;
    logic [63:0]  block;
    logic [255:0] key;
    logic [63:0]  encoded;
`ifdef MAGMA_ENCODER_VALID_EN
    logic         in_valid;
    logic         out_valid;

    modport master (output block, key, in_valid, input encoded, out_valid);
    modport slave  (input block, key, in_valid, output encoded, out_valid);
`else
    modport master (output block, key, input encoded);
    modport slave  (input block, key, output encoded);
`endif
endinterface

// File: rtl/magma_encoder_pipe.sv
// Fully pipelined Magma (GOST R 34.12-2015) 64-bit encryptor, 32 rounds x 2 stages, latency 64.
// Optional valid tracking under MAGMA_ENCODER_VALID_EN.
module magma_encoder_pipe (
    input logic clk,
    input logic rst,
    magma_encoder_pipe_if.slave bus
);
    localparam int ROUNDS = 32;

    // pi7 .. pi0; output for input x sits at bits [63-4x -: 4]
    localparam logic [7:0][63:0] PI = {
        64'h17ED05834FA69CB2, 64'h8E25691CF4B0DA37,
        64'h5DF692CAB78143E0, 64'h7F5A816D093EB42C,
        64'hC821D4F670A53E9B, 64'hB3582FADE174C960,
        64'h68239A5C1E47BD0F, 64'hC462A5B9E8D703F1
    };

    function automatic logic [31:0] sbox_rotl(input logic [31:0] s);
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 8; i++)
            t[4*i +: 4] = PI[i][60 - 4*int'(s[4*i +: 4]) +: 4];
        return {t[20:0], t[31:21]};
    endfunction

    for (genvar r = 0; r < ROUNDS; r++) begin : rnd
        // Key words are dropped once no later round needs them: rounds 25-32
        // consume K8..K1 from the low end, so the carried key shrinks by one word.
        localparam int W  = (r < 24) ? 8 : 32 - r;
        localparam int WN = (r < 23) ? 8 : 31 - r;
        localparam int KJ = (r < 24) ? r % 8 : W - 1;

        logic [31:0]     in_a1, in_a0;
        logic [32*W-1:0] in_key;
        logic [31:0]     s, a1, a0, f, o_a1, o_a0;

        if (r == 0) begin : src
            assign in_a1  = bus.block[63:32];
            assign in_a0  = bus.block[31:0];
            assign in_key = bus.key;
        end else begin : src
            assign in_a1  = rnd[r-1].o_a1;
            assign in_a0  = rnd[r-1].o_a0;
            assign in_key = rnd[r-1].kp.o_key;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s  <= '0;
                a1 <= '0;
                a0 <= '0;
            end else begin
                s  <= in_a0 + in_key[32*(W-KJ)-1 -: 32];
                a1 <= in_a1;
                a0 <= in_a0;
            end
        end

        assign f = sbox_rotl(s) ^ a1;

        always_ff @(posedge clk) begin
            if (rst) begin
                o_a1 <= '0;
                o_a0 <= '0;
            end else if (r == ROUNDS - 1) begin
                o_a1 <= f;
                o_a0 <= a0;
            end else begin
                o_a1 <= a0;
                o_a0 <= f;
            end
        end

        if (WN > 0) begin : kp
            logic [32*WN-1:0] k, o_key;
            always_ff @(posedge clk) begin
                if (rst) begin
                    k     <= '0;
                    o_key <= '0;
                end else begin
                    k     <= in_key[32*W-1 -: 32*WN];
                    o_key <= k;
                end
            end
        end
    end

    assign bus.encoded = {rnd[ROUNDS-1].o_a1, rnd[ROUNDS-1].o_a0};

`ifdef MAGMA_ENCODER_VALID_EN
    logic [2*ROUNDS-1:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[2*ROUNDS-2:0], bus.in_valid};
    end

    assign bus.out_valid = vld_pipe[2*ROUNDS-1];
`endif
endmodule

// File: tb/tb_magma_encoder_pipe.sv
// Scoreboard bench for magma_encoder_pipe: expected ciphertexts queued at drive time,
// popped 64 cycles later against encoded (and out_valid when MAGMA_ENCODER_VALID_EN is set).
module tb_magma_encoder_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    magma_encoder_pipe_if bus ();

    magma_encoder_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [255:0] KV = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  BV = 64'hfedcba9876543210;
    localparam logic [63:0]  EV = 64'h4ee901e5c2d8ca3d;

    localparam logic [63:0] SBT [8] = '{
        64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0, 64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
    };

    typedef struct {
        logic [63:0] val;
        bit          v;
        bit          early;
    } exp_t;

    exp_t        q[$];
    logic [63:0] disc[$];
    int ntests = 0;
    int nfail  = 0;

    function automatic logic [31:0] tb_g(input logic [31:0] k, input logic [31:0] a);
        logic [31:0] x, y;
        logic [63:0] row;
        x = a + k;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            row = SBT[i];
            row = row >> (4 * (15 - int'(x[4*i +: 4])));
            y[4*i +: 4] = row[3:0];
        end
        return (y << 11) | (y >> 21);
    endfunction

    function automatic logic [63:0] model(input logic [63:0] b, input logic [255:0] k);
        logic [31:0] a1, a0, t, kw;
        int ki;
        a1 = b[63:32];
        a0 = b[31:0];
        for (int r = 0; r < 32; r++) begin
            ki = (r < 24) ? r % 8 : 31 - r;
            kw = k[255 - 32*ki -: 32];
            t  = tb_g(kw, a0) ^ a1;
            if (r == 31) return {t, a0};
            a1 = a0;
            a0 = t;
        end
        return '0;
    endfunction

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic [63:0] b, input logic [255:0] k, input bit v,
                        input bit early, input logic [63:0] exp);
        exp_t e;
        bit   hit;
        bus.block = b;
        bus.key   = k;
`ifdef MAGMA_ENCODER_VALID_EN
        bus.in_valid = v;
`endif
        q.push_back('{exp, v, early});
        @(posedge clk); #1;
        if (q.size() == 64) begin
            e = q.pop_front();
            chk64("encoded", bus.encoded, e.val);
`ifdef MAGMA_ENCODER_VALID_EN
            chk1("out_valid", bus.out_valid, e.v);
`endif
        end else begin
            if (q[0].early && q.size() == 63) begin
                ntests++;
                assert (bus.encoded !== q[0].val) else begin
                    nfail++;
                    $error("FAIL early_output: got %h one cycle early, required not %h", bus.encoded, q[0].val);
                end
            end
            if (disc.size() > 0) begin
                hit = 1'b0;
                foreach (disc[i]) if (bus.encoded === disc[i]) hit = 1'b1;
                ntests++;
                assert (!hit) else begin
                    nfail++;
                    $error("FAIL stale_after_reset: got %h, required no pre-reset result", bus.encoded);
                end
            end
`ifdef MAGMA_ENCODER_VALID_EN
            chk1("out_valid_flush", bus.out_valid, 1'b0);
`endif
        end
    endtask

    task automatic do_reset(input int n);
        foreach (q[i]) disc.push_back(q[i].val);
        q.delete();
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            chk64("reset_encoded", bus.encoded, 64'h0);
`ifdef MAGMA_ENCODER_VALID_EN
            chk1("reset_out_valid", bus.out_valid, 1'b0);
`endif
        end
        rst = 1'b0;
    endtask

    task automatic rand_step(input bit v);
        logic [63:0]  b;
        logic [255:0] k;
        b = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        step(b, k, v, 1'b0, model(b, k));
    endtask

    initial begin
        bus.block = '0;
        bus.key   = '0;
`ifdef MAGMA_ENCODER_VALID_EN
        bus.in_valid = 1'b0;
`endif
        chk64("model_vector", model(BV, KV), EV);

        // reset held two cycles
        do_reset(2);

        // standard vector alone, single valid pulse, then unrelated traffic
        step(BV, KV, 1'b1, 1'b1, EV);
        for (int i = 0; i < 70; i++) rand_step(1'b0);

        // streaming, vector interleaved with random blocks/keys
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) step(BV, KV, 1'b1, 1'b0, EV);
            else            rand_step(1'b1);
        end

        // per-block keys alternating all-zero and the standard key
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step(BV, 256'h0, 1'b1, 1'b0, model(BV, 256'h0));
            else            step(BV, KV, 1'b1, 1'b0, EV);
        end

        // adder carry discard
        step(64'h00000000ffffffff, {8{32'h00000001}}, 1'b1, 1'b0,
             model(64'h00000000ffffffff, {8{32'h00000001}}));
        for (int i = 0; i < 70; i++) rand_step(1'b1);

        // reset mid-stream: in-flight blocks discarded
        disc.delete();
        do_reset(1);
        for (int i = 0; i < 130; i++) rand_step(1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
